// File: rtl/alu_pkg.sv
// Shared types for the accumulator ALU front-end.
// Operand width, op encoding and the queued command bundle.
package alu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_NOTB = 2'd2,
    ALU_GT   = 2'd3
  } alu_op_t;

  typedef struct packed {
    logic              load;
    alu_op_t           op;
    logic [DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/alu_accum_seq_if.sv
// Command and result ports of the accumulator front-end.
// master drives commands and consumes results; slave is the DUT.
interface alu_accum_seq_if
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  alu_op_t           cmd_op;
  logic              cmd_load;
  logic [DATA_W-1:0] cmd_data;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;

  logic [DATA_W-1:0] acc;
  logic [LW-1:0]     level;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_load,
    output cmd_data,
    output res_ready,
    input  cmd_ready,
    input  res_valid,
    input  res_data,
    input  acc,
    input  level
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_load,
    input  cmd_data,
    input  res_ready,
    output cmd_ready,
    output res_valid,
    output res_data,
    output acc,
    output level
  );

endinterface

// File: rtl/add_sub_logic.sv
// Combinational ALU: add, subtract, invert b, unsigned a > b.
// Arithmetic wraps modulo 2^DATA_W; no flags.
module add_sub_logic
  import alu_pkg::*;
(
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] r
);

  // Select the result for the requested operation.
  always_comb begin
    r = '0;
    unique case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_NOTB: r = ~b;
      ALU_GT:   r = {{(DATA_W-1){1'b0}}, (a > b)};
      default:  r = '0;
    endcase
  end

endmodule

// File: rtl/alu_accum_seq.sv
// Command FIFO feeding an accumulator ALU, one op per cycle.
// Result slot is a single valid/ready register.
module alu_accum_seq
  import alu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] ACC_INIT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_accum_seq_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  cmd_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [LW-1:0]     cnt_q;
  logic [LW-1:0]     cnt_d;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] res_data_q;
  logic [DATA_W-1:0] res_data_d;
  logic              res_valid_q;
  logic              res_valid_d;

  logic              full;
  logic              empty;
  logic              push;
  logic              exec;
  cmd_t              cmd_in;
  cmd_t              head;
  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] wb;

  assign full  = (cnt_q == FULL_LVL);
  assign empty = (cnt_q == '0);

  // No bypass on full: a pop in the same cycle does not free a slot.
  assign push = bus.cmd_valid && !full;
  assign exec = !empty && (!res_valid_q || bus.res_ready);

  assign cmd_in = '{
    load: bus.cmd_load,
    op:   bus.cmd_op,
    data: bus.cmd_data
  };

  assign head = mem_q[rd_q];

  add_sub_logic u_alu (
    .op (head.op),
    .a  (acc_q),
    .b  (head.data),
    .r  (alu_r)
  );

  assign wb = head.load ? head.data : alu_r;

  // Next-state for accumulator, result slot and occupancy.
  always_comb begin
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    cnt_d       = cnt_q;
    if (exec) begin
      acc_d       = wb;
      res_data_d  = wb;
      res_valid_d = 1'b1;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end
    unique case (1'b1)
      push && !exec: cnt_d = cnt_q + 1'b1;
      exec && !push: cnt_d = cnt_q - 1'b1;
      default:       cnt_d = cnt_q;
    endcase
  end

  // Control and datapath registers; reset discards queued work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= ACC_INIT;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (exec) rd_q <= rd_q + 1'b1;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Entry storage; contents are dead once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= cmd_in;
  end

  assign bus.cmd_ready = !full;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.acc       = acc_q;
  assign bus.level     = cnt_q;

endmodule
